// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU stage: opcodes and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_LOAD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_shift_mul.sv
// Sequential shift-add multiplier: loads A/B on start, then performs one
// partial-product step per clock for WIDTH clocks. done is high during the
// final step and product already shows the value that step produces, so the
// caller can register the full product on the same edge.
module alu_shift_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_next;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign product  = acc_next;
  assign done     = busy && (count == CW'(WIDTH - 1));

  // Load operands on start, then shift-add one multiplier bit per clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU stage feeding the accumulator. Snapshots acc_in and operand
// on accept, produces a registered result and a one-cycle acc_update strobe.
// Optional feature: define ALU_SAT_EN for unsigned saturation on overflow
// (ADD/MUL clamp to all-ones, SUB clamps to zero); default build wraps.
//
// state | meaning
// IDLE  | op_ready high, waiting for op_valid
// EXEC  | single-cycle op computed from latched operands
// MUL   | shift-add multiplier running WIDTH steps
// DONE  | acc_update high for this one cycle
import alu_pkg::*;

module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] result,
  output logic             acc_update,
  output logic             carry,
  output logic             zero
);

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_carry;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_carry;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign mul_start = (state == ST_IDLE) && op_valid && op_ready && (opcode == OP_MUL);

  alu_shift_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (acc_in),
    .b       (operand),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle ops evaluated at WIDTH+1 bits so bit WIDTH is carry/borrow.
  always_comb begin
    exec_res   = '0;
    exec_carry = 1'b0;
    case (op_q)
      OP_ADD:  {exec_carry, exec_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  {exec_carry, exec_res} = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_LOAD: exec_res = b_q;
      default: exec_res = '0;
    endcase
`ifdef ALU_SAT_EN
    if (exec_carry) exec_res = (op_q == OP_SUB) ? '0 : '1;
`endif
  end

  // Multiplier result: low half, overflow whenever the high half is non-zero.
  always_comb begin
    mul_carry = |mul_product[2*WIDTH-1:WIDTH];
    mul_res   = mul_product[WIDTH-1:0];
`ifdef ALU_SAT_EN
    if (mul_carry) mul_res = '1;
`endif
  end

  // Control FSM with registered outputs; acc_update is raised on entry to DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      op_ready   <= 1'b1;
      result     <= '0;
      acc_update <= 1'b0;
      carry      <= 1'b0;
      zero       <= 1'b1;
      op_q       <= OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      acc_update <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid && op_ready) begin
            op_q     <= opcode;
            a_q      <= acc_in;
            b_q      <= operand;
            op_ready <= 1'b0;
            state    <= (opcode == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_q == OP_NOP) begin
            state    <= ST_IDLE;
            op_ready <= 1'b1;
          end else begin
            result     <= exec_res;
            carry      <= exec_carry;
            zero       <= (exec_res == '0);
            acc_update <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result     <= mul_res;
            carry      <= mul_carry;
            zero       <= (mul_res == '0);
            acc_update <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed operations with literal expectations plus a
// transaction-level model checked against the DUT every cycle.
// Honours ALU_SAT_EN for the saturated expectations.
module tb_alu_seq;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [2:0]   opcode = 3'd0;
  logic [W-1:0] operand = '0;
  logic [W-1:0] acc_reg = '0;
  logic         op_ready;
  logic [W-1:0] result;
  logic         acc_update;
  logic         carry;
  logic         zero;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .opcode     (opcode),
    .operand    (operand),
    .acc_in     (acc_reg),
    .result     (result),
    .acc_update (acc_update),
    .carry      (carry),
    .zero       (zero)
  );

  always #5 clock = ~clock;

  // Accumulator register downstream of the ALU.
  always @(posedge clock) if (acc_update) acc_reg <= result;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int       rem = 0;       // clocks until the block is free again
  int       p_op = 0;
  int       p_res = 0;
  bit       p_c = 1'b0;
  int       m_res = 0;
  bit       m_c = 1'b0;
  bit       m_z = 1'b1;
  int       model_acc = 0;

  function automatic void calc(input int op, input int a, input int b,
                               output int r, output bit c);
    int full;
    r = 0;
    c = 1'b0;
    case (op)
      1: begin full = a + b; c = (full > 255); r = full % 256; end
      2: begin c = (a < b); r = (a - b + 256) % 256; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: begin full = a * b; c = (full > 255); r = full % 256; end
      7: r = b;
      default: r = 0;
    endcase
`ifdef ALU_SAT_EN
    if (c) r = (op == 2) ? 0 : 255;
`endif
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rem = 0; m_res = 0; m_c = 1'b0; m_z = 1'b1;
    end else if (rem > 0) begin
      rem--;
      if (rem == 1 && p_op != 0) begin
        m_res = p_res; m_c = p_c; m_z = (p_res == 0);
      end
      if (rem == 0 && p_op != 0) model_acc = m_res;
    end else if (op_valid) begin
      p_op = int'(opcode);
      calc(p_op, model_acc, int'(operand), p_res, p_c);
      rem = (p_op == 0) ? 1 : (p_op == 6) ? W + 1 : 2;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("mon_ready", int'(op_ready), int'(rem == 0));
      chk("mon_strobe", int'(acc_update), int'(rem == 1 && p_op != 0));
      chk("mon_result", int'(result), m_res);
      chk("mon_carry", int'(carry), int'(m_c));
      chk("mon_zero", int'(zero), int'(m_z));
      chk("mon_acc", int'(acc_reg), model_acc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [2:0] op, input logic [7:0] b);
    bit rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (op_ready) begin rdy = 1'b1; break; end
    end
    if (!rdy) begin
      errors++; checks++;
      $display("FAIL issue_wait: op_ready stayed 0 expected 1");
    end
    op_valid = 1'b1; opcode = op; operand = b;
    @(posedge clock);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string nm, input int exp_lat);
    bit seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (acc_update) begin
        seen = 1'b1;
        chk({nm, "_lat"}, k + 1, exp_lat);
        break;
      end
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL %s_strobe: acc_update 0 expected 1 within 20 edges", nm);
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] op, input logic [7:0] b,
                       input int lat, input int er, input int ec, input int ez);
    issue(op, b);
    wait_strobe(nm, lat);
    chk({nm, "_result"}, int'(result), er);
    chk({nm, "_carry"}, int'(carry), ec);
    chk({nm, "_zero"}, int'(zero), ez);
  endtask

  initial begin
    int lowcnt;
    bit rdy;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_result", int'(result), 0);
    chk("rst_strobe", int'(acc_update), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_ready", int'(op_ready), 1);
    @(negedge clock); #2 reset_n = 1'b1;

    // ADD with carry-out
    do_op("load_f0", 3'b111, 8'hF0, 2, 8'hF0, 0, 0);
`ifdef ALU_SAT_EN
    do_op("add_ovf", 3'b001, 8'h20, 2, 8'hFF, 1, 0);
`else
    do_op("add_ovf", 3'b001, 8'h20, 2, 8'h10, 1, 0);
`endif

    // SUB equal and borrow
    do_op("load_05", 3'b111, 8'h05, 2, 8'h05, 0, 0);
    do_op("sub_eq", 3'b010, 8'h05, 2, 8'h00, 0, 1);
    do_op("load_03", 3'b111, 8'h03, 2, 8'h03, 0, 0);
`ifdef ALU_SAT_EN
    do_op("sub_brw", 3'b010, 8'h04, 2, 8'h00, 1, 1);
`else
    do_op("sub_brw", 3'b010, 8'h04, 2, 8'hFF, 1, 0);
`endif

    // Logic ops on 8'hC3 with 8'h5A
    do_op("load_c3", 3'b111, 8'hC3, 2, 8'hC3, 0, 0);
    do_op("and", 3'b011, 8'h5A, 2, 8'h42, 0, 0);
    do_op("or", 3'b100, 8'h18, 2, 8'h5A, 0, 0);
    do_op("xor", 3'b101, 8'h5A, 2, 8'h00, 0, 1);

    // MUL overflow and plain
    do_op("load_12", 3'b111, 8'h12, 2, 8'h12, 0, 0);
`ifdef ALU_SAT_EN
    do_op("mul_ovf", 3'b110, 8'h10, 9, 8'hFF, 1, 0);
`else
    do_op("mul_ovf", 3'b110, 8'h10, 9, 8'h20, 1, 0);
`endif
    do_op("load_07", 3'b111, 8'h07, 2, 8'h07, 0, 0);
    do_op("mul_small", 3'b110, 8'h03, 9, 8'h15, 0, 0);

    // Back-to-back with op_valid held high
    rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (op_ready) begin rdy = 1'b1; break; end
    end
    chk("b2b_ready0", int'(rdy), 1);
    op_valid = 1'b1; opcode = 3'b111; operand = 8'h0A;
    @(posedge clock);
    #1 opcode = 3'b001; operand = 8'h01;
    lowcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (op_ready) break;
      lowcnt++;
    end
    chk("b2b_low_cycles", lowcnt, 2);
    @(posedge clock);
    #1 op_valid = 1'b0;
    chk("b2b_acc_snap", int'(acc_reg), 8'h0A);
    wait_strobe("b2b_add", 2);
    chk("b2b_result", int'(result), 8'h0B);
    chk("b2b_carry", int'(carry), 0);

    // NOP: no strobe, outputs held, ready after one edge
    issue(3'b000, 8'h55);
    chk("nop_ready_low", int'(op_ready), 0);
    chk("nop_strobe0", int'(acc_update), 0);
    @(posedge clock); #1;
    chk("nop_ready_high", int'(op_ready), 1);
    chk("nop_strobe1", int'(acc_update), 0);
    chk("nop_result", int'(result), 8'h0B);
    chk("nop_zero", int'(zero), 0);

    // Reset in the middle of a MUL
    issue(3'b110, 8'h03);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("mrst_result", int'(result), 0);
    chk("mrst_strobe", int'(acc_update), 0);
    chk("mrst_carry", int'(carry), 0);
    chk("mrst_zero", int'(zero), 1);
    chk("mrst_ready", int'(op_ready), 1);
    repeat (2) @(posedge clock);
    @(negedge clock); #2 reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      chk("mrst_no_strobe", int'(acc_update), 0);
    end
    chk("mrst_ready_after", int'(op_ready), 1);

    // Fresh op after the abandoned MUL: acc still 8'h0B
    do_op("post_add", 3'b001, 8'h05, 2, 8'h10, 0, 0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
